uart_tx: RTL
============

# uart_tx

Transmit half of the team's UART link: accepts parallel words over a valid/ready handshake and serialises them LSB-first onto `tx` as standard 8N1-style frames, with optional parity. It pairs with the existing UART receiver, using the same parameter set and clocking so the two ends can run back-to-back in loopback. It sits between on-chip producers (command/response logic, FIFOs) and the board UART pin.

## Interface
- `BUFFER_WIDTH`, 8: data bits per frame.
- `BAUD_RATE`, 115_200: line rate in bits/s.
- `CLK_FREQ`, 12_000_000: `clk` frequency in Hz.
- `STOP_BITS`, 1: number of stop bits; legal values are 1 or 2.
- `clk`  input  1  system clock.
- `rst_n`  input  1  reset; synchronous, active-low.
- `write_data`  input  BUFFER_WIDTH  word to send.
- `write_valid`  input  1  producer has a word on `write_data`.
- `write_ready`  output  1  transmitter can accept a word this cycle.
- `tx`  output  1  serial line; idles high.
- `busy`  output  1  a frame is in progress.

## Operation
- Bit period constants:
  - `CLK_CYCLES_PER_BIT` = `CLK_FREQ / BAUD_RATE`, using integer division. This is 104 at the defaults.
  - The clock counter is `$clog2(CLK_CYCLES_PER_BIT)` bits wide.
  - The bit counter is `$clog2(BUFFER_WIDTH)+1` bits wide.
- FSM states:
  - TX_RESET: unconditionally goes to TX_IDLE.
  - TX_IDLE: goes to TX_START on handshake.
  - TX_START: goes to TX_DATA after one bit period.
  - TX_DATA: goes to TX_PARITY (parity enabled) or TX_STOP (parity disabled) after BUFFER_WIDTH bit periods.
  - TX_PARITY: goes to TX_STOP after one bit period.
  - TX_STOP: goes to TX_IDLE after STOP_BITS bit periods.
  - Any illegal encoding goes to TX_RESET.
- Handshake:
  - A word transfers when `write_valid & write_ready` is true at a rising edge.
  - `write_ready` = 1 only in TX_IDLE.
  - `write_data` is captured into the internal shift register on the transfer edge; later changes to `write_data` have no effect on the frame.
  - `write_valid` without `write_ready` is ignored. No data is lost and no error is raised.
- Line levels:
  - TX_START drives `tx` = 0.
  - TX_DATA drives the shift register LSB, shifting right at the end of each bit period.
  - TX_STOP drives `tx` = 1.
  - TX_IDLE and TX_RESET drive `tx` = 1.
- `busy` = 1 in TX_START, TX_DATA, TX_PARITY and TX_STOP; otherwise 0.
- `tx` is driven from a flop, so it is glitch-free.

## Timing
- Outputs during reset and in TX_RESET: `tx` = 1, `write_ready` = 0, `busy` = 0.
- Shift register and counters clear on reset.
- Latency:
  - `tx` falls on the first edge after the transfer edge.
  - Every bit, including start, parity and stop, is held exactly `CLK_CYCLES_PER_BIT` cycles.
- Frame length is (1 + BUFFER_WIDTH + P + STOP_BITS) × `CLK_CYCLES_PER_BIT` cycles, where P = 1 with parity and 0 without. At the defaults without parity this is 1040 cycles.
- Back-to-back frames:
  - After the last stop bit the FSM spends at least one cycle in TX_IDLE, with `tx` high and `write_ready` high.
  - With `write_valid` held high, the minimum frame-to-frame spacing is frame length + 1 cycle.
- Reset mid-frame: the frame is abandoned, `tx` is high on the next edge, and the FSM enters TX_RESET.
- A `write_valid` edge coincident with deassertion of `rst_n` is not accepted, because `write_ready` is 0 in TX_RESET.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined:
  - The TX_PARITY state is compiled in.
  - It sends even parity: the XOR of the captured word.
  - The parity register is loaded at the transfer edge.
- Undefined:
  - No parity state, flop or logic exists.
  - The FSM goes TX_DATA → TX_STOP.

## Structure
- Shared package `uart_pkg`, holding:
  - `uart_tx_state_t`, one-hot style with TX_RESET = 0.
  - The receiver's state type.
  - A function computing `CLK_CYCLES_PER_BIT` from CLK_FREQ and BAUD_RATE.
- Sub-module `uart_baud_counter`:
  - Contains a down-counter with reload and a `bit_tick` pulse at count 0.
  - It is reusable by the receiver.
  - Held in reload while the FSM is in TX_IDLE or TX_RESET.

## Test plan
- Reset: hold `rst_n` = 0 for 5 cycles with `write_valid` = 1.
  - Required: `tx` = 1, `write_ready` = 0 and `busy` = 0 throughout.
  - Required: `write_ready` = 1 exactly 2 cycles after release.
- Single frame, 0x55, defaults, no parity:
  - Required line sequence: 0,1,0,1,0,1,0,1,0,1.
  - Each level lasts 104 cycles; `busy` is high for 1040 cycles.
- Capture isolation: send 0xA3, then change `write_data` to 0xFF one cycle after transfer. Required: the frame still carries 0xA3 (bits 1,1,0,0,0,1,0,1).
- Back-to-back: hold `write_valid` high with words 0x00 then 0xFF.
  - Required: two frames.
  - Required: start-to-start spacing is exactly 1041 cycles.
  - Required: exactly one idle-high cycle between the two frames.
- Parity, with `UART_TX_PARITY_EN` defined:
  - 0x07 requires parity bit 1; 0xA5 requires parity bit 0.
  - Required: frame length is 1144 cycles.
- Reset mid-frame and loopback:
  - Assert `rst_n` = 0 during data bit 3. Required: `tx` = 1 on the next edge.
  - Then loop `tx` into the receiver and send 0x3C. Required: the receiver reports 0x3C.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by the UART transmitter and receiver.
// Build option: UART_TX_PARITY_EN adds the transmitter's even-parity state.
package uart_pkg;

  // Transmitter states, one-hot with the reset state at all-zeros.
  typedef enum logic [4:0] {
    TX_RESET  = 5'b00000,
    TX_IDLE   = 5'b00001,
    TX_START  = 5'b00010,
    TX_DATA   = 5'b00100,
`ifdef UART_TX_PARITY_EN
    TX_PARITY = 5'b01000,
`endif
    TX_STOP   = 5'b10000
  } uart_tx_state_t;

  // Receiver states, same encoding style as the transmitter.
  typedef enum logic [4:0] {
    RX_RESET  = 5'b00000,
    RX_IDLE   = 5'b00001,
    RX_START  = 5'b00010,
    RX_DATA   = 5'b00100,
    RX_PARITY = 5'b01000,
    RX_STOP   = 5'b10000
  } uart_rx_state_t;

  // Clock cycles per line bit; integer division, so the rate is rounded down.
  function automatic int unsigned clk_cycles_per_bit(input int unsigned clk_freq,
                                                     input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: bit-period timer shared by the UART transmitter and receiver.
// Counts down from CYCLES_PER_BIT-1 to 0 and pulses bit_tick on the last cycle of
// each bit period. While reload is high the counter sits at its reload value, so
// the first period after reload is released is a full CYCLES_PER_BIT cycles.
module uart_baud_counter #(
  parameter int unsigned CYCLES_PER_BIT = 104,
  parameter int unsigned CNT_WIDTH      = $clog2(CYCLES_PER_BIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  output logic bit_tick
);

  localparam logic [CNT_WIDTH-1:0] RELOAD_VAL = CNT_WIDTH'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};

  logic [CNT_WIDTH-1:0] count_r;
  logic                 at_zero_s;

  assign at_zero_s = (count_r == CNT_ZERO);
  assign bit_tick  = at_zero_s && !reload;

  // Down-count one bit period, reloading at zero or while held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= CNT_ZERO;
    end else if (reload || at_zero_s) begin
      count_r <= RELOAD_VAL;
    end else begin
      count_r <= count_r - CNT_ONE;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Takes a word over write_valid/write_ready and sends
// it LSB-first as start bit, BUFFER_WIDTH data bits, optional parity, STOP_BITS
// stop bits. tx, busy and write_ready are all flop outputs. tx and busy follow the
// state one cycle later, so the start bit appears on the edge after the transfer.
// Build option: UART_TX_PARITY_EN inserts an even-parity bit after the data bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BUFFER_WIDTH = 8,
  parameter int unsigned BAUD_RATE    = 115_200,
  parameter int unsigned CLK_FREQ     = 12_000_000,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BUFFER_WIDTH-1:0] write_data,
  input  logic                    write_valid,
  output logic                    write_ready,
  output logic                    tx,
  output logic                    busy
);

  localparam int unsigned CLK_CYCLES_PER_BIT = clk_cycles_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CLK_CNT_WIDTH      = $clog2(CLK_CYCLES_PER_BIT);
  localparam int unsigned BIT_CNT_WIDTH      = $clog2(BUFFER_WIDTH) + 1;

  localparam logic [BIT_CNT_WIDTH-1:0] LAST_DATA_BIT = BIT_CNT_WIDTH'(BUFFER_WIDTH - 1);
  localparam logic [BIT_CNT_WIDTH-1:0] LAST_STOP_BIT = BIT_CNT_WIDTH'(STOP_BITS - 1);
  localparam logic [BIT_CNT_WIDTH-1:0] BIT_CNT_ONE   = BIT_CNT_WIDTH'(1);
  localparam logic [BIT_CNT_WIDTH-1:0] BIT_CNT_ZERO  = {BIT_CNT_WIDTH{1'b0}};

  uart_tx_state_t            state_r;
  logic [BUFFER_WIDTH-1:0]   shift_r;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt_r;
  logic                      tx_r;
  logic                      busy_r;
  logic                      ready_r;
  logic                      hold_s;
  logic                      bit_tick_s;
`ifdef UART_TX_PARITY_EN
  logic                      parity_r;

  // Even parity: the XOR of all data bits.
  function automatic logic even_parity(input logic [BUFFER_WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  // The bit timer only runs while a frame is on the line.
  assign hold_s = (state_r == TX_IDLE) || (state_r == TX_RESET);

  uart_baud_counter #(
    .CYCLES_PER_BIT (CLK_CYCLES_PER_BIT),
    .CNT_WIDTH      (CLK_CNT_WIDTH)
  ) u_baud_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .reload   (hold_s),
    .bit_tick (bit_tick_s)
  );

  // Frame sequencer: state, shift register, bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= TX_RESET;
      shift_r   <= {BUFFER_WIDTH{1'b0}};
      bit_cnt_r <= BIT_CNT_ZERO;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      ready_r   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      ready_r <= 1'b0;
      case (state_r)
        TX_RESET: begin
          tx_r      <= 1'b1;
          busy_r    <= 1'b0;
          bit_cnt_r <= BIT_CNT_ZERO;
          state_r   <= TX_IDLE;
        end
        TX_IDLE: begin
          tx_r      <= 1'b1;
          busy_r    <= 1'b0;
          bit_cnt_r <= BIT_CNT_ZERO;
          if (write_valid && ready_r) begin
            shift_r  <= write_data;
`ifdef UART_TX_PARITY_EN
            parity_r <= even_parity(write_data);
`endif
            state_r  <= TX_START;
          end else begin
            ready_r  <= 1'b1;
          end
        end
        TX_START: begin
          tx_r   <= 1'b0;
          busy_r <= 1'b1;
          if (bit_tick_s) begin
            state_r <= TX_DATA;
          end
        end
        TX_DATA: begin
          tx_r   <= shift_r[0];
          busy_r <= 1'b1;
          if (bit_tick_s) begin
            shift_r <= {1'b0, shift_r[BUFFER_WIDTH-1:1]};
            if (bit_cnt_r == LAST_DATA_BIT) begin
              bit_cnt_r <= BIT_CNT_ZERO;
`ifdef UART_TX_PARITY_EN
              state_r   <= TX_PARITY;
`else
              state_r   <= TX_STOP;
`endif
            end else begin
              bit_cnt_r <= bit_cnt_r + BIT_CNT_ONE;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        TX_PARITY: begin
          tx_r   <= parity_r;
          busy_r <= 1'b1;
          if (bit_tick_s) begin
            state_r <= TX_STOP;
          end
        end
`endif
        TX_STOP: begin
          tx_r   <= 1'b1;
          busy_r <= 1'b1;
          if (bit_tick_s) begin
            if (bit_cnt_r == LAST_STOP_BIT) begin
              bit_cnt_r <= BIT_CNT_ZERO;
              ready_r   <= 1'b1;
              state_r   <= TX_IDLE;
            end else begin
              bit_cnt_r <= bit_cnt_r + BIT_CNT_ONE;
            end
          end
        end
        default: begin
          tx_r      <= 1'b1;
          busy_r    <= 1'b0;
          bit_cnt_r <= BIT_CNT_ZERO;
          state_r   <= TX_RESET;
        end
      endcase
    end
  end

  assign tx          = tx_r;
  assign busy        = busy_r;
  assign write_ready = ready_r;

endmodule
